// File: rtl/fifo_pack_reader_if.sv
// fifo_pack_reader_if: FIFO read port and packed-word valid/ready port
interface fifo_pack_reader_if #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam int CNT_W = $clog2(PACK_RATIO + 1);
  logic                  fifo_rd_val;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  flush;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [CNT_W-1:0]      out_count;
  logic                  out_valid;
  logic                  out_ready;
  modport master (
    input  fifo_rd_val, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_data, out_count, out_valid
  );
  modport slave (
    output fifo_rd_val, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, out_data, out_count, out_valid
  );
endinterface

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: pops narrow FIFO words and packs them into one wide valid/ready word
module fifo_pack_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4
) (
  input logic              clk,
  input logic              reset,
  fifo_pack_reader_if.master bus
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam int CNT_W = $clog2(PACK_RATIO + 1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 rd_en_q, rd_en_d;
  logic [OUT_WIDTH-1:0] lanes_q, lanes_d;
  logic                 pop;
  // next state: capture the word popped last edge, then decide fill/hold/flush, and precompute rd_en
  always_comb begin
    pop = rd_en_q & bus.fifo_rd_val;
    state_d = state_q;
    count_d = count_q;
    pending_d = pop;
    flush_pend_d = flush_pend_q;
    lanes_d = lanes_q;
    if (pending_q) begin
      lanes_d[count_q*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_rd_data;
      count_d = count_q + CNT_W'(1);
    end
    if (state_q == FILL) begin
      flush_pend_d = flush_pend_q | bus.flush;
      if (count_d == CNT_W'(PACK_RATIO)) state_d = HOLD;
      else if (flush_pend_q && !pending_q) begin
        state_d = (count_q != '0) ? HOLD : FILL;
        flush_pend_d = (count_q != '0) ? flush_pend_d : 1'b0;
      end
    end else if (bus.out_ready) begin
      state_d = FILL;
      lanes_d = '0;
      count_d = '0;
      flush_pend_d = 1'b0;
    end
    rd_en_d = (state_d == FILL) && !flush_pend_d &&
              (({1'b0, count_d} + {{CNT_W{1'b0}}, pending_d}) < (CNT_W+1)'(PACK_RATIO));
  end
  // state registers with asynchronous active-low reset; rd_en is registered so reset forces it low at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      count_q <= '0;
      pending_q <= 1'b0;
      flush_pend_q <= 1'b0;
      rd_en_q <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pending_q <= pending_d;
      flush_pend_q <= flush_pend_d;
      rd_en_q <= rd_en_d;
      lanes_q <= lanes_d;
    end
  end
  assign bus.fifo_rd_en = rd_en_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data = lanes_q;
  assign bus.out_count = (state_q == HOLD) ? count_q : '0;
endmodule

// File: tb/tb_fifo_pack_reader.sv
// tb_fifo_pack_reader: directed stimulus with a queue-based packing model checked every cycle
module tb_fifo_pack_reader;
  localparam int DW = 4;
  localparam int PR = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int full_at = -1;
  logic gap_en = 1'b0;
  logic phase = 1'b0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mw[$];

  always #5 clk = ~clk;

  fifo_pack_reader_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();
  fifo_pack_reader #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // expected packed word: popped words in order, first one in the lowest lane
  function automatic logic [31:0] packw();
    logic [31:0] r;
    r = '0;
    foreach (mw[i]) r |= 32'(mw[i]) << (DW * i);
    return r;
  endfunction

  // model and per-cycle compare, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mw.delete();
      full_at = -1;
      chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_count", 32'(bus.out_count), 0);
    end else begin
      if (full_at >= 0 && cyc == full_at + 2) begin
        chk("latency", 32'(bus.out_valid), 1);
        full_at = -1;
      end
      if (bus.out_valid) begin
        chk("rd_en_in_hold", 32'(bus.fifo_rd_en), 0);
        chk("model_data", 32'(bus.out_data), packw());
        chk("model_count", 32'(bus.out_count), mw.size());
        if (bus.out_ready) mw.delete();
      end else
        chk("idle_count", 32'(bus.out_count), 0);
      if (bus.fifo_rd_en && bus.fifo_rd_val) begin
        mw.push_back(fq[0]);
        chk("overpop", 32'(mw.size() <= PR), 1);
        if (mw.size() == PR) full_at = cyc;
      end
    end
  end

  // one clock: note whether a pop happens at the edge, then model the FIFO's 1-cycle read latency
  task automatic tick();
    logic p;
    @(negedge clk);
    p = bus.fifo_rd_en && bus.fifo_rd_val;
    @(posedge clk);
    #1;
    if (p) bus.fifo_rd_data = fq.pop_front();
    phase = ~phase;
    bus.fifo_rd_val = (fq.size() > 0) && (!gap_en || phase);
  endtask

  task automatic wait_valid(input int n);
    int k;
    k = 0;
    while (!bus.out_valid && k < n) begin
      tick();
      k++;
    end
    chk("wait_valid", 32'(bus.out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fifo_rd_val = 1'b0;
    bus.fifo_rd_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_rd_en", 32'(bus.fifo_rd_en), 0);
    // full pack
    reset = 1'b1;
    fq = '{4'h7, 4'h6, 4'h5, 4'h4};
    bus.fifo_rd_val = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("full_rd_en_on", 32'(bus.fifo_rd_en), 1);
      tick();
    end
    chk("full_rd_en_off", 32'(bus.fifo_rd_en), 0);
    chk("full_not_yet", 32'(bus.out_valid), 0);
    tick();
    chk("full_valid", 32'(bus.out_valid), 1);
    chk("full_data", 32'(bus.out_data), 32'h4567);
    chk("full_count", 32'(bus.out_count), 4);
    tick();
    chk("full_valid_1cyc", 32'(bus.out_valid), 0);
    chk("full_rd_en_back", 32'(bus.fifo_rd_en), 1);
    // backpressure
    bus.out_ready = 1'b0;
    fq = '{4'h7, 4'h6, 4'h5, 4'h4};
    bus.fifo_rd_val = 1'b1;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_rd_en", 32'(bus.fifo_rd_en), 0);
      chk("bp_data", 32'(bus.out_data), 32'h4567);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.out_valid), 0);
    chk("bp_release_rd_en", 32'(bus.fifo_rd_en), 1);
    // gapped source
    gap_en = 1'b1;
    fq = '{4'h9, 4'hA, 4'hB, 4'hC};
    bus.fifo_rd_val = 1'b1;
    wait_valid(40);
    chk("gap_data", 32'(bus.out_data), 32'hCBA9);
    chk("gap_count", 32'(bus.out_count), 4);
    gap_en = 1'b0;
    tick();
    // partial flush after both captures
    fq = '{4'h3, 4'h9};
    bus.fifo_rd_val = 1'b1;
    tick();
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_valid(10);
    chk("flush_data", 32'(bus.out_data), 32'h0093);
    chk("flush_count", 32'(bus.out_count), 2);
    tick();
    // partial flush raised in the cycle of the second pop
    fq = '{4'h3, 4'h9};
    bus.fifo_rd_val = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_valid(10);
    chk("flush2_data", 32'(bus.out_data), 32'h0093);
    chk("flush2_count", 32'(bus.out_count), 2);
    tick();
    // empty flush
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("eflush_rd_en_low", 32'(bus.fifo_rd_en), 0);
    chk("eflush_valid", 32'(bus.out_valid), 0);
    tick();
    chk("eflush_rd_en_back", 32'(bus.fifo_rd_en), 1);
    chk("eflush_valid2", 32'(bus.out_valid), 0);
    tick();
    chk("eflush_valid3", 32'(bus.out_valid), 0);
    // reset mid-fill
    fq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    bus.fifo_rd_val = 1'b1;
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("async_valid", 32'(bus.out_valid), 0);
    chk("async_data", 32'(bus.out_data), 0);
    chk("async_count", 32'(bus.out_count), 0);
    tick();
    reset = 1'b1;
    fq.push_back(4'h7);
    wait_valid(20);
    chk("post_rst_data", 32'(bus.out_data), 32'h7654);
    chk("post_rst_count", 32'(bus.out_count), 4);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
